// File: rtl/frame_draw_sequencer.sv
// frame_draw_sequencer
// Frame pacer and draw sequencer for NUM_CH sprite/layer channels. A free
// running counter produces a frame tick. On each enabled tick the channels
// are started one after another. The active channel's pixel stream is
// registered towards the VGA write port. A tick that arrives while a frame
// is still in progress sets a sticky overrun flag.
// Optional feature macro: TRANSPARENT_KEY_EN. When it is defined, pixels whose
// colour equals TRANSPARENT_KEY are not written. x/y/colour still update.
module frame_draw_sequencer #(
  parameter int NUM_CH          = 3,
  parameter int X_W             = 9,
  parameter int Y_W             = 8,
  parameter int C_W             = 6,
  parameter int CNT_W           = 28,
  parameter int FRAME_CYCLES    = 833333,
  parameter int TRANSPARENT_KEY = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH*X_W-1:0]   ch_x,
  input  logic [NUM_CH*Y_W-1:0]   ch_y,
  input  logic [NUM_CH*C_W-1:0]   ch_colour,
  input  logic [NUM_CH-1:0]       ch_write,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_start,
  output logic [X_W-1:0]          x_position,
  output logic [Y_W-1:0]          y_position,
  output logic [C_W-1:0]          colour,
  output logic                    VGA_enable,
  output logic                    frame_tick,
  output logic                    busy,
  output logic [3:0]              active_ch,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_START = 2'd1,
    S_DRAW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [3:0]       LAST_CH  = 4'(NUM_CH - 1);
  localparam logic [C_W-1:0]   KEY      = C_W'(TRANSPARENT_KEY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       k_q, k_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [C_W-1:0]   c_q, c_d;
  logic             vga_en_q, vga_en_d;
  logic             overrun_q, overrun_d;

  logic              tick_s;
  logic [X_W-1:0]    sel_x_s;
  logic [Y_W-1:0]    sel_y_s;
  logic [C_W-1:0]    sel_c_s;
  logic              sel_w_s;
  logic              sel_done_s;
  logic              pass_s;
  logic [NUM_CH-1:0] start_vec_s;

  assign tick_s = (cnt_q == LAST_CNT);

  // Frame counter: wraps after the last cycle of the frame period.
  always_comb begin
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Select the current channel's pixel stream and decode its start pulse.
  always_comb begin
    sel_x_s     = '0;
    sel_y_s     = '0;
    sel_c_s     = '0;
    sel_w_s     = 1'b0;
    sel_done_s  = 1'b0;
    start_vec_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (k_q == 4'(i)) begin
        sel_x_s        = ch_x[i*X_W +: X_W];
        sel_y_s        = ch_y[i*Y_W +: Y_W];
        sel_c_s        = ch_colour[i*C_W +: C_W];
        sel_w_s        = ch_write[i];
        sel_done_s     = ch_done[i];
        start_vec_s[i] = (state_q == S_START);
      end else begin
        start_vec_s[i] = 1'b0;
      end
    end
  end

  // Write qualification: optionally suppress key-coloured pixels.
  always_comb begin
`ifdef TRANSPARENT_KEY_EN
    pass_s = (sel_c_s != KEY);
`else
    // The key only matters in keyed builds; every strobed pixel passes here.
    pass_s = 1'b1 | (sel_c_s == KEY);
`endif
  end

  // Sequencer next state: wait for an enabled tick, then start/draw each channel.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_WAIT: begin
        if (tick_s && enable) begin
          state_d = S_START;
          k_d     = 4'd0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_START: begin
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (sel_done_s) begin
          if (k_q == LAST_CH) begin
            state_d = S_WAIT;
            k_d     = 4'd0;
          end else begin
            state_d = S_START;
            k_d     = k_q + 4'd1;
          end
        end else begin
          state_d = S_DRAW;
        end
      end
      default: begin
        state_d = S_WAIT;
        k_d     = 4'd0;
      end
    endcase
  end

  // Output stage next values: only the drawing channel reaches the VGA port.
  always_comb begin
    if (state_q == S_DRAW) begin
      vga_en_d = sel_w_s & ~sel_done_s & pass_s;
      x_d      = sel_x_s;
      y_d      = sel_y_s;
      c_d      = sel_c_s;
    end else begin
      vga_en_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
      c_d      = '0;
    end
    overrun_d = overrun_q | (tick_s && (state_q != S_WAIT));
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      k_q       <= 4'd0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      vga_en_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c_q       <= c_d;
      vga_en_q  <= vga_en_d;
      overrun_q <= overrun_d;
    end
  end

  assign ch_start   = start_vec_s;
  assign x_position = x_q;
  assign y_position = y_q;
  assign colour     = c_q;
  assign VGA_enable = vga_en_q;
  assign frame_tick = tick_s;
  assign busy       = (state_q != S_WAIT);
  assign active_ch  = (state_q == S_WAIT) ? 4'd0 : k_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Scoreboard bench for frame_draw_sequencer (NUM_CH=3, FRAME_CYCLES=16).
// The stimulus process advances a behavioural frame model every clock edge
// and pushes the expected output bundle. A monitor pops it on the falling
// edge and compares it against the DUT.
module tb_frame_draw_sequencer;
  localparam int N  = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 6;
  localparam int FC = 16;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_DRAW  = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [N*XW-1:0] ch_x = '0;
  logic [N*YW-1:0] ch_y = '0;
  logic [N*CW-1:0] ch_colour = '0;
  logic [N-1:0]    ch_write = '0;
  logic [N-1:0]    ch_done = '0;
  logic [N-1:0]    ch_start;
  logic [XW-1:0]   x_position;
  logic [YW-1:0]   y_position;
  logic [CW-1:0]   colour;
  logic            VGA_enable;
  logic            frame_tick;
  logic            busy;
  logic [3:0]      active_ch;
  logic            overrun;

  frame_draw_sequencer #(
    .NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW), .CNT_W(28),
    .FRAME_CYCLES(FC), .TRANSPARENT_KEY(0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour),
    .ch_write(ch_write), .ch_done(ch_done), .ch_start(ch_start),
    .x_position(x_position), .y_position(y_position), .colour(colour),
    .VGA_enable(VGA_enable), .frame_tick(frame_tick), .busy(busy),
    .active_ch(active_ch), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0]  start;
    logic          tick;
    logic          busy;
    logic [3:0]    act;
    logic          ovr;
    logic          ve;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: frame position, current channel and the VGA registers.
  int            m_cnt   = 0;
  int            m_phase = P_IDLE;
  int            m_k     = 0;
  bit            m_ovr   = 1'b0;
  bit            m_ve    = 1'b0;
  logic [XW-1:0] m_x     = '0;
  logic [YW-1:0] m_y     = '0;
  logic [CW-1:0] m_c     = '0;

  // Environment controls.
  bit rst_req = 1'b1;
  bit en_req  = 1'b1;
  int delay[N] = '{4, 4, 4};
  int rem[N]   = '{0, 0, 0};
  bit fix_ch1  = 1'b0;
  bit key_seq  = 1'b0;
  bit key_tog  = 1'b0;

  function automatic obs_t model_obs();
    obs_t o;
    o.start = (m_phase == P_START) ? N'(1 << m_k) : '0;
    o.tick  = (m_cnt == FC - 1);
    o.busy  = (m_phase != P_IDLE);
    o.act   = (m_phase == P_IDLE) ? 4'd0 : 4'(m_k);
    o.ovr   = m_ovr;
    o.ve    = m_ve;
    o.x     = m_x;
    o.y     = m_y;
    o.c     = m_c;
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic step_model();
    bit tick;
    int k;
    tick = (m_cnt == FC - 1);
    k = m_k;
    if (reset) begin
      m_cnt = 0; m_phase = P_IDLE; m_k = 0; m_ovr = 1'b0;
      m_ve = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    end else begin
      if (m_phase == P_DRAW) begin
        m_ve = ch_write[k] & ~ch_done[k];
`ifdef TRANSPARENT_KEY_EN
        if (ch_colour[k*CW +: CW] == 6'h00) m_ve = 1'b0;
`endif
        m_x = ch_x[k*XW +: XW];
        m_y = ch_y[k*YW +: YW];
        m_c = ch_colour[k*CW +: CW];
      end else begin
        m_ve = 1'b0; m_x = '0; m_y = '0; m_c = '0;
      end
      if (tick && m_phase != P_IDLE) m_ovr = 1'b1;
      if (m_phase == P_IDLE) begin
        if (tick && enable) begin
          m_phase = P_START;
          m_k = 0;
        end
      end else if (m_phase == P_START) begin
        m_phase = P_DRAW;
      end else if (ch_done[k]) begin
        if (k == N - 1) begin
          m_phase = P_IDLE;
          m_k = 0;
        end else begin
          m_phase = P_START;
          m_k = k + 1;
        end
      end
      m_cnt = (m_cnt == FC - 1) ? 0 : m_cnt + 1;
    end
  endtask

  // Drive channel drawers from the model's own view of the start pulses.
  task automatic drive_env(input obs_t e);
    logic [N*XW-1:0] vx;
    logic [N*YW-1:0] vy;
    logic [N*CW-1:0] vc;
    logic [N-1:0]    vw;
    logic [N-1:0]    vd;
    for (int k = 0; k < N; k++) begin
      if (e.start[k]) begin
        rem[k] = delay[k];
        vd[k]  = 1'b0;
      end else begin
        if (rem[k] > 0) rem[k] = rem[k] - 1;
        vd[k] = (rem[k] == 0);
      end
      vx[k*XW +: XW] = XW'($urandom);
      vy[k*YW +: YW] = YW'($urandom);
      vc[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? 6'h00 : CW'($urandom);
      vw[k] = ($urandom_range(0, 99) < 80);
    end
    if (fix_ch1) begin
      vx[XW +: XW] = 9'd100;
      vy[YW +: YW] = 8'd50;
      vc[CW +: CW] = 6'h2A;
      vw[1] = 1'b1;
    end
    if (key_seq) begin
      vc[0 +: CW] = key_tog ? 6'h15 : 6'h00;
      vw[0] = 1'b1;
      key_tog = ~key_tog;
    end
    ch_x = vx; ch_y = vy; ch_colour = vc; ch_write = vw; ch_done = vd;
    reset = rst_req;
    enable = en_req;
  endtask

  task automatic cycle();
    obs_t e;
    @(posedge clock);
    #1;
    step_model();
    e = model_obs();
    exp_q.push_back(e);
    drive_env(e);
  endtask

  // Monitor: compare the DUT's outputs with the oldest expected bundle.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ch_start, frame_tick, busy, active_ch, overrun, VGA_enable,
             x_position, y_position, colour};
        n_checks++;
        if (a === e) begin
          n_pass++;
        end else begin
          $display("FAIL out_check @%0t got start=%b tick=%b busy=%b act=%0d ovr=%b ve=%b x=%0d y=%0d c=%h want start=%b tick=%b busy=%b act=%0d ovr=%b ve=%b x=%0d y=%0d c=%h",
                   $time, a.start, a.tick, a.busy, a.act, a.ovr, a.ve, a.x, a.y, a.c,
                   e.start, e.tick, e.busy, e.act, e.ovr, e.ve, e.x, e.y, e.c);
        end
      end
    end
  end

  initial begin
    int guard;
    // Reset, then free-running frames with done 4 cycles after start.
    repeat (3) cycle();
    rst_req = 1'b0;
    repeat (60) cycle();
    // Channel 1 draws a fixed pixel.
    fix_ch1 = 1'b1;
    repeat (40) cycle();
    fix_ch1 = 1'b0;
    // Channel 2 runs long enough to overrun the frame.
    delay[2] = 20;
    repeat (80) cycle();
    delay[2] = 4;
    // Enable low across two ticks, then raised.
    rst_req = 1'b1; en_req = 1'b0;
    cycle();
    rst_req = 1'b0;
    repeat (40) cycle();
    en_req = 1'b1;
    repeat (40) cycle();
    // Reset while channel 1 is drawing.
    guard = 0;
    while (!(m_phase == P_DRAW && m_k == 1) && guard < 200) begin
      cycle();
      guard++;
    end
    n_checks++;
    if (guard < 200) begin
      n_pass++;
    end else begin
      $display("FAIL reach_ch1_draw got timeout after %0d cycles want ch1 draw", guard);
    end
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    repeat (30) cycle();
    // Channel 0 alternates key colour and a visible colour.
    key_seq = 1'b1;
    repeat (40) cycle();
    key_seq = 1'b0;
    // Minimum-length frames: done on the first draw cycle.
    delay = '{1, 1, 1};
    repeat (60) cycle();
    // Randomised traffic with enable toggles, delay changes and rare resets.
    repeat (1500) begin
      rst_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) en_req = ~en_req;
      if ($urandom_range(0, 15) == 0) delay[$urandom_range(0, N - 1)] = $urandom_range(1, 12);
      cycle();
    end
    rst_req = 1'b0; en_req = 1'b1;
    repeat (40) cycle();
    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
